md_unit: RTL and testbench

//   Multi-cycle multiply/divide responder for the 5-stage pipeline. The E stage

---
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers. mthi/mtlo write
// in one edge; mult/div run for a fixed cycle count and pulse done on completion.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_RSV6  = 3'd6,
      OP_RSV7  = 3'd7
   } md_op_e;

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state;
   md_op_e           op_q;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [CNT_W-1:0] count;

   logic [63:0] a_sext, b_sext, prod_s, prod_u;
   logic        is_sdiv, a_neg, b_neg;
   logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, quot, rem;
   logic [31:0] res_hi, res_lo;

   // Division runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 instead of trapping.
   always_comb begin
      a_sext  = {{32{op_a[31]}}, op_a};
      b_sext  = {{32{op_b[31]}}, op_b};
      prod_s  = a_sext * b_sext;
      prod_u  = {32'd0, op_a} * {32'd0, op_b};
      is_sdiv = (op_q == OP_DIV);
      a_neg   = is_sdiv & op_a[31];
      b_neg   = is_sdiv & op_b[31];
      mag_a   = a_neg ? (~op_a + 32'd1) : op_a;
      mag_b   = b_neg ? (~op_b + 32'd1) : op_b;
      div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
      q_mag   = mag_a / div_b;
      r_mag   = mag_a % div_b;
      quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

      // NOTE: defaults first so every path assigns res_hi/res_lo and no latch is inferred.
      res_hi = hi;
      res_lo = lo;
      case (op_q)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV, OP_DIVU: begin
            if (op_b != 32'd0) begin
               res_hi = rem;
               res_lo = quot;
            end
         end
         default: ;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
         count <= '0;
         op_q  <= OP_MULT;
         op_a  <= 32'd0;
         op_b  <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (md_op_e'(md_op))
                     OP_MTHI: hi <= src_a;
                     OP_MTLO: lo <= src_a;
                     OP_MULT, OP_MULTU: begin
                        op_q  <= md_op_e'(md_op);
                        op_a  <= src_a;
                        op_b  <= src_b;
                        count <= CNT_W'(MULT_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        op_q  <= md_op_e'(md_op);
                        op_a  <= src_a;
                        op_b  <= src_b;
                        count <= CNT_W'(DIV_CYCLES);
                        state <= RUN;
                        busy  <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            RUN: begin
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= res_hi;
                  lo    <= res_lo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized op
// sequences compared against a plain-arithmetic model of HI/LO.
module tb_md_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Reference: new {hi,lo} from the instruction semantics using 64-bit integers.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] oh,
                                         input logic [31:0] ol);
      longint      sa, sb;
      logic [63:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = {oh, ol};
      case (op)
         3'd0: r = 64'(sa * sb);
         3'd1: r = {32'd0, a} * {32'd0, b};
         3'd2: if (b != 32'd0) r = {32'(sa % sb), 32'(sa / sb)};
         3'd3: if (b != 32'd0) r = {a % b, a / b};
         3'd4: r = {a, ol};
         3'd5: r = {oh, a};
         default: ;
      endcase
      return r;
   endfunction

   function automatic int exp_busy(input logic [2:0] op);
      return (op < 3'd2) ? MULT_N : (op < 3'd4) ? DIV_N : 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and follow it until busy drops (bounded); flags any HI/LO
   // movement or early done while busy, then advances the model.
   task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output bit hold_ok);
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      step();
      start = 1'b0; src_a = $urandom; src_b = $urandom;
      busy_cycles = 0;
      hold_ok     = 1'b1;
      while (busy === 1'b1 && busy_cycles < 64) begin
         if (hi !== m_hi || lo !== m_lo || done !== 1'b0) hold_ok = 1'b0;
         busy_cycles++;
         step();
      end
      {m_hi, m_lo} = model(op, a, b, m_hi, m_lo);
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
      repeat (2) step();
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++; $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
      end
      reset = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_release got busy=%b done=%b want 0 0", busy, done);
      end
      m_hi = 32'd0; m_lo = 32'd0;
   endtask

   task automatic test_mult();
      int bc; bit hold;
      exec_op(3'd0, 32'hFFFF_FFFD, 32'd5, bc, hold);
      checks++;
      if (bc !== MULT_N || !hold) begin
         errors++; $display("FAIL mult_busy got %0d cycles hold=%b want %0d hold=1", bc, hold, MULT_N);
      end
      checks++;
      if (done !== 1'b1 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
         errors++; $display("FAIL mult_result got done=%b %h_%h want 1 ffffffff_fffffff1", done, hi, lo);
      end
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mult_done_width got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_multu();
      int bc; bit hold;
      exec_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, hold);
      checks++;
      if (bc !== MULT_N || !hold || done !== 1'b1 || {hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL multu got %0d cycles hold=%b done=%b %h_%h want %0d 1 1 fffffffe_00000001",
                            bc, hold, done, hi, lo, MULT_N);
      end
      step();
   endtask

   task automatic test_div();
      int bc; bit hold;
      exec_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, hold);
      checks++;
      if (bc !== DIV_N || !hold) begin
         errors++; $display("FAIL div_busy got %0d cycles hold=%b want %0d hold=1", bc, hold, DIV_N);
      end
      checks++;
      if (done !== 1'b1 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         errors++; $display("FAIL div_result got done=%b %h_%h want 1 ffffffff_fffffffd", done, hi, lo);
      end
      step();
   endtask

   task automatic test_divu_zero();
      int bc; bit hold;
      exec_op(3'd4, 32'h11, $urandom, bc, hold);
      checks++;
      if (bc !== 0 || done !== 1'b0 || hi !== 32'h11) begin
         errors++; $display("FAIL mthi got %0d cycles done=%b hi=%h want 0 0 00000011", bc, done, hi);
      end
      exec_op(3'd5, 32'h22, $urandom, bc, hold);
      checks++;
      if (bc !== 0 || done !== 1'b0 || lo !== 32'h22) begin
         errors++; $display("FAIL mtlo got %0d cycles done=%b lo=%h want 0 0 00000022", bc, done, lo);
      end
      exec_op(3'd3, 32'd7, 32'd0, bc, hold);
      checks++;
      if (bc !== DIV_N || !hold || done !== 1'b1 || {hi, lo} !== 64'h0000_0011_0000_0022) begin
         errors++; $display("FAIL divu_zero got %0d cycles hold=%b done=%b %h_%h want %0d 1 1 00000011_00000022",
                            bc, hold, done, hi, lo, DIV_N);
      end
      step();
   endtask

   task automatic test_ignore_busy();
      int          bc;
      logic [63:0] exp;
      start = 1'b1; md_op = 3'd0; src_a = 32'h1234; src_b = 32'h5678;
      step();
      start = 1'b0;
      step();
      start = 1'b1; md_op = 3'd5; src_a = 32'hAB;
      step();
      start = 1'b0; md_op = 3'd0;
      bc = 2;
      while (busy === 1'b1 && bc < 64) begin
         bc++;
         step();
      end
      exp = model(3'd0, 32'h1234, 32'h5678, m_hi, m_lo);
      {m_hi, m_lo} = exp;
      checks++;
      if (bc !== MULT_N || done !== 1'b1 || {hi, lo} !== exp) begin
         errors++; $display("FAIL ignore_busy got %0d cycles done=%b %h_%h want %0d 1 %h", bc, done, hi, lo, MULT_N, exp);
      end
      start = 1'b1; md_op = 3'd5; src_a = 32'hAB;
      step();
      start = 1'b0;
      m_lo = 32'hAB;
      checks++;
      if (lo !== 32'hAB || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mtlo_after_done got lo=%h hi=%h busy=%b done=%b want 000000ab %h 0 0", lo, hi, busy, done, m_hi);
      end
   endtask

   task automatic test_reset_mid();
      int bc; bit hold; bit bad;
      exec_op(3'd4, 32'hDEAD_BEEF, 32'd0, bc, hold);
      exec_op(3'd5, 32'h0BAD_F00D, 32'd0, bc, hold);
      start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd7;
      step();
      start = 1'b0;
      repeat (3) step();
      checks++;
      if (busy !== 1'b1 || {hi, lo} !== 64'hDEAD_BEEF_0BAD_F00D) begin
         errors++; $display("FAIL reset_mid_pre got busy=%b %h_%h want 1 deadbeef_0badf00d", busy, hi, lo);
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      m_hi = 32'd0; m_lo = 32'd0;
      checks++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         errors++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
      end
      bad = 1'b0;
      repeat (DIV_N + 2) begin
         step();
         if ({busy, done, hi, lo} !== 66'd0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL reset_mid_abort got late activity=1 want 0");
      end
      reset = 1'b0; start = 1'b1; md_op = 3'd4; src_a = 32'h55;
      step();
      checks++;
      if (hi !== 32'd0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_vs_mthi got hi=%h busy=%b want 00000000 0", hi, busy);
      end
      md_op = 3'd0; src_a = 32'd3; src_b = 32'd3;
      step();
      reset = 1'b1; start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'd0) begin
         errors++; $display("FAIL reset_vs_mult got busy=%b done=%b %h_%h want 0 0 0", busy, done, hi, lo);
      end
   endtask

   task automatic test_div_overflow();
      int bc; bit hold;
      exec_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, hold);
      checks++;
      if (bc !== DIV_N || done !== 1'b1 || {hi, lo} !== 64'h0000_0000_8000_0000) begin
         errors++; $display("FAIL div_overflow got %0d cycles done=%b %h_%h want %0d 1 00000000_80000000",
                            bc, done, hi, lo, DIV_N);
      end
      step();
   endtask

   task automatic test_reserved();
      int bc; bit hold;
      exec_op(3'd4, 32'h600D, 32'd0, bc, hold);
      exec_op(3'd5, 32'hF00D, 32'd0, bc, hold);
      for (int op = 6; op <= 7; op++) begin
         exec_op(3'(op), $urandom, $urandom, bc, hold);
         checks++;
         if (bc !== 0 || busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'h0000_600D_0000_F00D) begin
            errors++; $display("FAIL reserved_op%0d got %0d cycles busy=%b done=%b %h_%h want 0 0 0 0000600d_0000f00d",
                               op, bc, busy, done, hi, lo);
         end
      end
   endtask

   task automatic test_back_to_back();
      int bc; bit hold;
      exec_op(3'd3, 32'd100, 32'd7, bc, hold);
      checks++;
      if (done !== 1'b1 || {hi, lo} !== 64'h0000_0002_0000_000E) begin
         errors++; $display("FAIL b2b_first got done=%b %h_%h want 1 00000002_0000000e", done, hi, lo);
      end
      exec_op(3'd0, 32'hFFFF_FFFE, 32'd3, bc, hold);
      checks++;
      if (bc !== MULT_N || !hold || done !== 1'b1 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
         errors++; $display("FAIL b2b_second got %0d cycles hold=%b done=%b %h_%h want %0d 1 1 ffffffff_fffffffa",
                            bc, hold, done, hi, lo, MULT_N);
      end
      step();
   endtask

   task automatic test_random();
      int          bc;
      bit          hold;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000; b = 32'hFFFF_FFFF;
         end
         exec_op(op, a, b, bc, hold);
         checks++;
         if (bc !== exp_busy(op) || !hold || done !== (op < 3'd4) || hi !== m_hi || lo !== m_lo) begin
            errors++; $display("FAIL random_%0d op=%0d a=%h b=%h got %0d cycles hold=%b done=%b %h_%h want %0d 1 %b %h_%h",
                               i, op, a, b, bc, hold, done, hi, lo, exp_busy(op), (op < 3'd4), m_hi, m_lo);
         end
         if ($urandom_range(0, 2) == 0) step();
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_divu_zero();
      test_ignore_busy();
      test_reset_mid();
      test_div_overflow();
      test_reserved();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
